// File: rtl/chimpo_mem_pkg.sv
// Shared memory-map constants and types for the Chimpo memory/I-O sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package chimpo_mem_pkg;

  // Inclusive upper bounds of the two memory regions, plus the two port addresses.
  localparam logic [15:0] ROM_END  = 16'h00FF;
  localparam logic [15:0] RAM_END  = 16'h01FF;
  localparam logic [15:0] IN_PORT  = 16'h0400;
  localparam logic [15:0] OUT_PORT = 16'h0402;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    MEM,
    RESP,
    IN_WAIT,
    OUT_WAIT,
    ERR
  } state_e;

  // Region an address falls into. BAD covers unmapped and misaligned addresses.
  typedef enum logic [2:0] {
    ROM,
    RAM,
    IN,
    OUT,
    BAD
  } region_e;

endpackage

// File: rtl/mem_map_decode.sv
// Combinational memory-map decode: address + op -> region and access error.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the result is consumed in the cycle it is produced.
module mem_map_decode
  import chimpo_mem_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic        rd_i,
  input  logic        wr_i,
  output region_e     region_o,
  output logic        err_o
);

  // Region lookup first, then legality of the requested op in that region.
  always_comb begin
    region_o = BAD;
    if (addr_i[0]) begin
      region_o = BAD;
    end else if (addr_i <= ROM_END) begin
      region_o = ROM;
    end else if (addr_i <= RAM_END) begin
      region_o = RAM;
    end else if (addr_i == IN_PORT) begin
      region_o = IN;
    end else if (addr_i == OUT_PORT) begin
      region_o = OUT;
    end

    err_o = 1'b0;
    // Exactly one of read/write must be requested.
    if (rd_i == wr_i) begin
      err_o = 1'b1;
    end else begin
      case (region_o)
        ROM:     err_o = wr_i;
        RAM:     err_o = 1'b0;
        IN:      err_o = wr_i;
        OUT:     err_o = rd_i;
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates fetch vs load/store onto one memory port and sequences I/O port handshakes.
// Latency: memory ack 2 cycles after grant, map error 1 cycle, ports 1..IO_TIMEOUT cycles.
// Backpressure: requests are held until their ack; the loser waits; ports bounded by IO_TIMEOUT.
module mem_access_arbiter
  import chimpo_mem_pkg::*;
#(
  parameter int IO_TIMEOUT = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ack,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int WW = $clog2(IO_TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e          state_q, state_d;
  logic            fetch_q, fetch_d;
  logic            wr_q, wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;

  logic            d_req;
  logic            grant_f;
  logic            grant_d;
  logic [15:0]     sel_addr;
  logic            sel_rd;
  logic            sel_wr;
  region_e         sel_region;
  logic            sel_err;
  logic            timeout;
  logic            ack;
  logic            err;
  logic [15:0]     rdata;

  // Winner selection: data has priority unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    d_req    = d_re | d_we;
    grant_f  = if_req && (!d_req || (starve_cnt_q == SW'(STARVE_MAX)));
    grant_d  = d_req && !grant_f;
    sel_addr = grant_f ? if_addr : d_addr;
    sel_rd   = grant_f ? 1'b1 : d_re;
    sel_wr   = grant_f ? 1'b0 : d_we;
    timeout  = (wait_cnt_q == WW'(IO_TIMEOUT - 1));
  end

  mem_map_decode u_decode (
    .addr_i   (sel_addr),
    .rd_i     (sel_rd),
    .wr_i     (sel_wr),
    .region_o (sel_region),
    .err_o    (sel_err)
  );

  // Next-state and output decode; all outputs derive from the registered state.
  always_comb begin
    state_d      = state_q;
    fetch_d      = fetch_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    ack          = 1'b0;
    err          = 1'b0;
    rdata        = 16'h0000;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    in_ack       = 1'b0;
    out_data     = 16'h0000;
    out_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_f || grant_d) begin
          fetch_d    = grant_f;
          wr_d       = sel_wr;
          addr_d     = sel_addr;
          wdata_d    = d_wdata;
          wait_cnt_d = '0;
          if (grant_f) begin
            starve_cnt_d = '0;
          end else if (if_req) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
          if (sel_err) begin
            state_d = ERR;
          end else begin
            case (sel_region)
              ROM, RAM: state_d = MEM;
              IN:       state_d = IN_WAIT;
              OUT:      state_d = OUT_WAIT;
              default:  state_d = ERR;
            endcase
          end
        end
      end
      MEM: begin
        mem_addr  = addr_q;
        mem_re    = !wr_q;
        mem_we    = wr_q;
        mem_wdata = wr_q ? wdata_q : 16'h0000;
        state_d   = RESP;
      end
      RESP: begin
        ack     = 1'b1;
        rdata   = wr_q ? 16'h0000 : mem_rdata;
        state_d = IDLE;
      end
      IN_WAIT: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        // A handshake arriving in the timeout cycle still completes normally.
        if (in_valid) begin
          in_ack  = 1'b1;
          ack     = 1'b1;
          rdata   = in_data;
          state_d = IDLE;
        end else if (timeout) begin
          ack     = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      OUT_WAIT: begin
        wait_cnt_d = wait_cnt_q + WW'(1);
        out_valid  = 1'b1;
        out_data   = wdata_q;
        if (out_ready) begin
          ack     = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          out_valid = 1'b0;
          out_data  = 16'h0000;
          ack       = 1'b1;
          err       = 1'b1;
          state_d   = IDLE;
        end
      end
      ERR: begin
        ack     = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fetcher that is not asking cannot be starved.
    if (!if_req) begin
      starve_cnt_d = '0;
    end
  end

  // Route the shared completion to whichever requester owns the access in flight.
  always_comb begin
    if_ack   = ack && fetch_q;
    if_err   = err && fetch_q;
    if_rdata = (ack && fetch_q) ? rdata : 16'h0000;
    d_ack    = ack && !fetch_q;
    d_err    = err && !fetch_q;
    d_rdata  = (ack && !fetch_q) ? rdata : 16'h0000;
  end

  // State and access-context registers; reset drops any access in flight.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetch_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= fetch_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed steps plus randomized accesses.
// Latency expectations come from a request-level model of the memory map and handshakes.
// Port devices raise in_valid/out_ready after a programmable number of cycles.
module tb_mem_access_arbiter;

  localparam int IO_TIMEOUT = 64;
  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        d_re = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ack;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  mem_access_arbiter #(.IO_TIMEOUT(IO_TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] init_val(input int i);
    return (16'(i) * 16'h0123) ^ 16'hA55A;
  endfunction

  // Synchronous-read memory covering 0x0000-0x01FF, one word per even address.
  logic [15:0] mem_arr [0:255];
  bit          mem_init_done = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem_arr[mem_addr[8:1]] <= mem_wdata;
    end
    mem_rdata <= mem_re ? mem_arr[mem_addr[8:1]] : 16'h0000;
  end

  // Reference model state: expected memory contents.
  logic [15:0] ref_mem [0:255];

  function automatic bit map_err(input logic [15:0] a, input bit rd, input bit wr);
    if (rd == wr)       return 1'b1;
    if (a[0])           return 1'b1;
    if (a < 16'h0100)   return wr;
    if (a < 16'h0200)   return 1'b0;
    if (a == 16'h0400)  return wr;
    if (a == 16'h0402)  return rd;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ctl"}, 32'({if_ack, if_err, d_ack, d_err, mem_re, mem_we, in_ack, out_valid}), 32'd0);
    chk({tag, ".dat"}, 32'(if_rdata | d_rdata | mem_addr | mem_wdata | out_data), 32'd0);
  endtask

  // Observations from the last access.
  int          r_lat, r_strobes, r_ov, r_ov_bad, r_inack, r_wrong_ack, r_leak;
  logic        r_err, r_swe;
  logic [15:0] r_rdata, r_saddr, r_swdata;

  task automatic run_access(input bit is_f, input bit re, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, input int in_dly, input int out_dly,
                            input logic [15:0] idat);
    int c;
    bit done;
    r_lat = -1; r_err = 1'b0; r_rdata = 16'h0; r_strobes = 0; r_ov = 0; r_ov_bad = 0;
    r_inack = 0; r_wrong_ack = 0; r_leak = 0; r_saddr = 16'h0; r_swdata = 16'h0; r_swe = 1'b0;
    if (is_f) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_re = re; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    in_data = idat;
    c = 0;
    done = 1'b0;
    while (!done) begin
      in_valid  = (in_dly >= 0) && (c >= in_dly);
      out_ready = (out_dly >= 0) && (c >= out_dly);
      @(negedge CLK);
      if (mem_re || mem_we) begin
        r_strobes++; r_saddr = mem_addr; r_swdata = mem_wdata; r_swe = mem_we;
      end
      if (out_valid) begin
        r_ov++;
        if (out_data !== wdata) r_ov_bad++;
      end
      if (in_ack) r_inack++;
      if ((is_f && d_ack) || (!is_f && if_ack)) r_wrong_ack++;
      if ((!if_ack && if_rdata !== 16'h0) || (!d_ack && d_rdata !== 16'h0)) r_leak++;
      if (is_f ? if_ack : d_ack) begin
        r_lat   = c;
        r_err   = is_f ? if_err : d_err;
        r_rdata = is_f ? if_rdata : d_rdata;
        done    = 1'b1;
      end
      @(posedge CLK); #1;
      c++;
      if (c > 200) done = 1'b1;
    end
    if_req = 1'b0; d_re = 1'b0; d_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    // Exactly one ack pulse: nothing may follow once the request is withdrawn.
    @(negedge CLK);
    if (if_ack || d_ack) r_wrong_ack++;
    @(posedge CLK); #1;
  endtask

  task automatic check_access(input string tag, input bit is_f, input bit re, input bit we,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input int in_dly, input int out_dly, input logic [15:0] idat);
    bit rd, wr, merr, is_mem, is_in, is_out, tmo;
    int lat, ov;
    logic [15:0] rdat;
    rd = is_f ? 1'b1 : re;
    wr = is_f ? 1'b0 : we;
    merr   = map_err(addr, rd, wr);
    is_mem = !merr && (addr < 16'h0200);
    is_in  = !merr && (addr == 16'h0400);
    is_out = !merr && (addr == 16'h0402);
    tmo = 1'b0; ov = 0; rdat = 16'h0; lat = 1;
    if (is_mem) begin
      lat = 2;
      if (rd) rdat = ref_mem[addr[8:1]];
    end else if (is_in) begin
      if (in_dly < 0 || in_dly > IO_TIMEOUT) begin
        lat = IO_TIMEOUT; tmo = 1'b1;
      end else begin
        lat = (in_dly < 1) ? 1 : in_dly; rdat = idat;
      end
    end else if (is_out) begin
      if (out_dly < 0 || out_dly > IO_TIMEOUT) begin
        lat = IO_TIMEOUT; tmo = 1'b1; ov = IO_TIMEOUT - 1;
      end else begin
        lat = (out_dly < 1) ? 1 : out_dly; ov = lat;
      end
    end
    run_access(is_f, re, we, addr, wdata, in_dly, out_dly, idat);
    chk({tag, ".lat"},     32'(r_lat),       32'(lat));
    chk({tag, ".err"},     32'(r_err),       32'(merr | tmo));
    chk({tag, ".rdata"},   32'(r_rdata),     32'(rdat));
    chk({tag, ".strobes"}, 32'(r_strobes),   32'(is_mem ? 1 : 0));
    chk({tag, ".in_ack"},  32'(r_inack),     32'((is_in && !tmo) ? 1 : 0));
    chk({tag, ".ov_cyc"},  32'(r_ov),        32'(ov));
    chk({tag, ".ov_dat"},  32'(r_ov_bad),    32'd0);
    chk({tag, ".acks"},    32'(r_wrong_ack), 32'd0);
    chk({tag, ".leak"},    32'(r_leak),      32'd0);
    if (is_mem) begin
      chk({tag, ".saddr"}, 32'(r_saddr), 32'(addr));
      chk({tag, ".swe"},   32'(r_swe),   32'(wr));
      if (wr) begin
        chk({tag, ".swdata"}, 32'(r_swdata), 32'(wdata));
        ref_mem[addr[8:1]] = wdata;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got_f [0:9];
    logic [15:0] got_d [0:9];
    int          n, cyc, scnt, cat, op;
    bit          exp_f, rf;
    logic [15:0] a;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    // Reset state.
    #12;
    chk_quiet("reset");
    @(posedge CLK); #1;
    chk_quiet("reset2");
    reset_n = 1'b1;
    @(posedge CLK); #1;

    // Memory accesses and map errors.
    check_access("st_ram",    0, 0, 1, 16'h0100, 16'hBEEF, -1, -1, 16'h0);
    check_access("ld_ram",    0, 1, 0, 16'h0100, 16'h0000, -1, -1, 16'h0);
    check_access("st_rom",    0, 0, 1, 16'h0010, 16'h1111, -1, -1, 16'h0);
    check_access("ld_mis",    0, 1, 0, 16'h0101, 16'h0000, -1, -1, 16'h0);
    check_access("ld_rom",    0, 1, 0, 16'h00FE, 16'h0000, -1, -1, 16'h0);
    check_access("ld_both",   0, 1, 1, 16'h0100, 16'h2222, -1, -1, 16'h0);
    check_access("ld_unmap",  0, 1, 0, 16'h0200, 16'h0000, -1, -1, 16'h0);
    check_access("f_rom",     1, 0, 0, 16'h0004, 16'h0000, -1, -1, 16'h0);
    check_access("f_out",     1, 0, 0, 16'h0402, 16'h0000, -1, -1, 16'h0);
    check_access("f_in",      1, 0, 0, 16'h0400, 16'h0000,  2, -1, 16'h7E57);

    // I/O ports.
    check_access("out_rdy4",  0, 0, 1, 16'h0402, 16'h1234, -1,  4, 16'h0);
    check_access("out_tmo",   0, 0, 1, 16'h0402, 16'h1234, -1, -1, 16'h0);
    check_access("out_edge",  0, 0, 1, 16'h0402, 16'h4321, -1, IO_TIMEOUT, 16'h0);
    check_access("in_1",      0, 1, 0, 16'h0400, 16'h0000,  1, -1, 16'h00A5);
    check_access("in_tmo",    0, 1, 0, 16'h0400, 16'h0000, IO_TIMEOUT + 1, -1, 16'h0055);
    check_access("in_edge",   0, 1, 0, 16'h0400, 16'h0000, IO_TIMEOUT, -1, 16'h0066);
    check_access("st_in",     0, 0, 1, 16'h0400, 16'h3333, 1, -1, 16'h0077);
    check_access("ld_out",    0, 1, 0, 16'h0402, 16'h0000, -1, 1, 16'h0);

    // Starvation bound with both requesters held continuously.
    if_req = 1'b1; if_addr = 16'h0002; d_re = 1'b1; d_addr = 16'h0100;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(negedge CLK);
      chk("starve.both_ack", 32'(if_ack & d_ack), 32'd0);
      if (if_ack || d_ack) begin
        got_f[n] = if_ack;
        got_d[n] = if_ack ? if_rdata : d_rdata;
        n++;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    if_req = 1'b0; d_re = 1'b0;
    @(posedge CLK); #1;
    chk("starve.count", 32'(n), 32'd10);
    scnt = 0;
    for (int k = 0; k < n; k++) begin
      exp_f = (scnt == STARVE_MAX);
      scnt  = exp_f ? 0 : scnt + 1;
      chk($sformatf("starve.who%0d", k), 32'(got_f[k]), 32'(exp_f));
      chk($sformatf("starve.dat%0d", k), 32'(got_d[k]),
          32'(exp_f ? ref_mem[1] : ref_mem[8'h80]));
    end

    // Reset asserted while a store is driving the memory strobe.
    d_we = 1'b1; d_addr = 16'h0120; d_wdata = 16'h5A5A;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst.mem_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_quiet("rst.drop");
    repeat (2) begin
      @(posedge CLK); #1;
      chk_quiet("rst.hold");
    end
    reset_n = 1'b1;
    check_access("rst.reissue", 0, 0, 1, 16'h0120, 16'h5A5A, -1, -1, 16'h0);
    check_access("rst.readback", 0, 1, 0, 16'h0120, 16'h0000, -1, -1, 16'h0);

    // Randomized accesses from either requester.
    for (int it = 0; it < 40; it++) begin
      cat = $urandom_range(0, 5);
      rf  = 1'($urandom_range(0, 1));
      case (cat)
        0:       a = 16'($urandom_range(0, 127)) * 16'd2;
        1:       a = 16'h0100 + 16'($urandom_range(0, 127)) * 16'd2;
        2:       a = 16'h0400;
        3:       a = 16'h0402;
        4:       a = 16'h0200 + 16'($urandom_range(0, 255)) * 16'd2;
        default: a = 16'($urandom_range(0, 1023)) * 16'd2 + 16'd1;
      endcase
      op = $urandom_range(0, 7);
      check_access($sformatf("rnd%0d", it), rf, (op == 0) || (op < 4), (op == 0) || (op >= 4), a,
                   16'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequential arbiter and sequencer for the single-ported data memory and the memory-mapped I/O ports of the Chimpo processor. It shares one memory port between the instruction-fetch requester and the load/store requester, and decodes each granted address against the system memory map. It drives the memory strobes for exactly one cycle per access and runs bounded handshakes with the input and output ports. Every request finishes with one ack pulse, which carries an error flag on a map violation or an I/O timeout.

## Interface
- `IO_TIMEOUT`, 64: cycles an I/O access may wait for its handshake before it is aborted with error.
- `STARVE_MAX`, 4: consecutive data grants allowed while a fetch is pending.
- `CLK` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in 16: fetch address.
- `if_rdata` out 16: fetch data, valid with `if_ack`.
- `if_ack` out 1: one-cycle fetch completion.
- `if_err` out 1: fetch error, valid with `if_ack`.
- `d_re`, `d_we` in 1: load / store request, held until `d_ack`; both high together is an error.
- `d_addr` in 16: data address.
- `d_wdata` in 16: store data.
- `d_rdata` out 16: load data, valid with `d_ack`.
- `d_ack` out 1: one-cycle data completion.
- `d_err` out 1: data error, valid with `d_ack`.
- `mem_addr` out 16, `mem_wdata` out 16, `mem_re` out 1, `mem_we` out 1: memory port.
- `mem_rdata` in 16: memory read data, one cycle after `mem_re`.
- `in_data` in 16, `in_valid` in 1: input port data and valid.
- `in_ack` out 1: input port consume pulse.
- `out_data` out 16, `out_valid` out 1: output port data and valid.
- `out_ready` in 1: output port ready.

## Operation
- Memory map, evaluated on the granted address:
  - Bit 0 set: misaligned, error.
  - 0x0000–0x00FF: read-only; a store here is an error.
  - 0x0100–0x01FF: read/write.
  - 0x0400: input port, load only; a store is an error.
  - 0x0402: output port, store only; a load is an error.
  - All other addresses: error.
- Arbitration, sampled only in IDLE:
  - Data wins over fetch.
  - `starve_cnt` counts data grants issued while `if_req` is high. It clears on any fetch grant and whenever `if_req` is low.
  - When `starve_cnt == STARVE_MAX` and `if_req` is high, fetch wins.
- Fetch uses read semantics with the same map rules: a fetch of 0x0400 is allowed, a fetch of 0x0402 is an error.
- FSM states:
  - `IDLE`: register the winner, its address, wdata and op. Go to `MEM` if the access is legal memory, `IN_WAIT` or `OUT_WAIT` for a legal port access, `ERR` otherwise. Stay in `IDLE` if there is no request.
  - `MEM`: drive `mem_addr`. Assert `mem_re` or `mem_we` for this one cycle only. Go to `RESP`.
  - `RESP`: pulse ack. Read data comes from `mem_rdata`. Go to `IDLE`.
  - `IN_WAIT`:
    - On `in_valid`: pulse `in_ack` and ack together, return `in_data`, go to `IDLE`.
    - On timeout: ack with error, no `in_ack`.
  - `OUT_WAIT`:
    - Hold `out_valid=1` and `out_data`.
    - On `out_ready`: pulse ack, go to `IDLE`.
    - On timeout: drop `out_valid`, ack with error.
  - `ERR`: ack with error, rdata 0, no strobes, go to `IDLE`.
- `wait_cnt` (width log2 of `IO_TIMEOUT`+1) clears on entry to a wait state and increments each cycle. The access times out in the cycle where `wait_cnt == IO_TIMEOUT-1` and the handshake is still absent. If the handshake and the timeout fall in the same cycle, the handshake wins.
- Read data outputs are 0 whenever the matching ack is low.

## Timing
- Request sampled in IDLE at cycle N:
  - Legal memory access: strobe at N+1, ack at N+2, back in IDLE at N+3.
  - Map error: ack+err at N+1.
  - Port with handshake already present at N+1: ack at N+1.
- Requester must drop or change its request in the cycle after ack. A request still high in IDLE is treated as a new request.
- At most one access is in flight; the losing requester waits.
- Reset, asynchronous and applied in any state:
  - State goes to IDLE; both counters go to 0.
  - All strobes, acks, errs, `in_ack` and `out_valid` go to 0; all data outputs go to 0.
  - An interrupted access is dropped without an ack. Requests still held are re-sampled in the first IDLE cycle after release.

## Structure
- Shared package `chimpo_mem_pkg`:
  - Region bounds: `ROM_END`=0x00FF, `RAM_END`=0x01FF, `IN_PORT`=0x0400, `OUT_PORT`=0x0402.
  - FSM state enum.
  - Decode result type (`ROM`, `RAM`, `IN`, `OUT`, `BAD`).
- Sub-module `mem_map_decode`: combinational address+op → decode result and error. This replaces the standalone decoder in the processor top.

## Test plan
- Load at 0x0100 with memory holding 0xBEEF: `mem_re` at N+1, `d_ack=1`, `d_rdata=0xBEEF` at N+2, no error.
- Store at 0x0010 (ROM), and separately a load at 0x0101: `d_ack=d_err=1` at N+1, `mem_re`/`mem_we` never asserted.
- `if_req` and `d_re` held continuously (STARVE_MAX=4): grant order D,D,D,D,F,D,D,D,D,F; no requester waits longer than 5 accesses.
- Store 0x1234 to 0x0402 with `out_ready` rising after 3 cycles: `out_valid` held with 0x1234 for 4 cycles, `d_ack` in the cycle `out_ready` is high. Repeat with `out_ready` never high: `d_ack=d_err=1` after 64 wait cycles.
- Load 0x0400 with `in_valid` high at cycle N+1 and `in_data`=0x00A5: `in_ack`, `d_ack`, `d_rdata`=0x00A5 all at N+1.
- `reset_n` pulsed low during `MEM` of a store: `mem_we` and all outputs drop immediately, no ack. After release the held store re-issues and completes normally.
